// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file:
// clear-FSM state encoding and a constant-width helper.
package regfile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_st_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1)
      r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// Bulk-clear sequencer: IDLE -> CLEAR (one entry per cycle) -> DONE.
// Ports: clk, rst (async low), clrReq in; fsmIdle, clrBusy, clrDone,
// clrWrEn, clrIdx out.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clrReq,
  output logic             fsmIdle,
  output logic             clrBusy,
  output logic             clrDone,
  output logic             clrWrEn,
  output logic [SEL_W-1:0] clrIdx
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_REGS - 1);

  clr_st_e          r_state;
  clr_st_e          w_next;
  logic [SEL_W-1:0] r_idx;
  logic [SEL_W-1:0] w_idx_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      r_idx   <= w_idx_nxt;
    end
  end

  // Index returns to 0 on exit so it never wraps.
  always_comb begin
    w_next    = r_state;
    w_idx_nxt = r_idx;
    unique case (r_state)
      ST_IDLE: begin
        if (clrReq) begin
          w_next    = ST_CLEAR;
          w_idx_nxt = '0;
        end
      end
      ST_CLEAR: begin
        if (r_idx == LAST) begin
          w_next    = ST_DONE;
          w_idx_nxt = '0;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next    = ST_IDLE;
        w_idx_nxt = '0;
      end
    endcase
  end

  assign fsmIdle = (r_state == ST_IDLE);
  assign clrBusy = (r_state == ST_CLEAR);
  assign clrDone = (r_state == ST_DONE);
  assign clrWrEn = (r_state == ST_CLEAR);
  assign clrIdx  = r_idx;

endmodule

// File: rtl/regfile_param_clr.sv
// Parametrised register file: 2 comb read ports, 1 write port,
// optional write->read bypass, bulk clear, registered err pulse.
// Ports: clk, rst (async low); read1/2RegSel -> read1/2Data;
// writeRegSel/writeData/writeEn; clrReq -> clrBusy/clrDone; err.
module regfile_param_clr
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = clog2(NUM_REGS),
  parameter bit BYPASS   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] read1RegSel,
  input  logic [SEL_W-1:0] read2RegSel,
  input  logic [SEL_W-1:0] writeRegSel,
  input  logic [WIDTH-1:0] writeData,
  input  logic             writeEn,
  input  logic             clrReq,
  output logic [WIDTH-1:0] read1Data,
  output logic [WIDTH-1:0] read2Data,
  output logic             clrBusy,
  output logic             clrDone,
  output logic             err
);

  logic [WIDTH-1:0] r_regs [NUM_REGS];
  logic             r_err;

  logic             w_idle;
  logic             w_clr_we;
  logic [SEL_W-1:0] w_clr_idx;

  logic             w_r1_ok;
  logic             w_r2_ok;
  logic             w_wr_rng;
  logic             w_wr_ok;
  logic             w_byp1;
  logic             w_byp2;
  logic             w_illegal;
  logic [WIDTH-1:0] w_rd1;
  logic [WIDTH-1:0] w_rd2;

  regfile_clr_fsm #(
    .NUM_REGS (NUM_REGS),
    .SEL_W    (SEL_W)
  ) u_fsm (
    .clk     (clk),
    .rst     (rst),
    .clrReq  (clrReq),
    .fsmIdle (w_idle),
    .clrBusy (clrBusy),
    .clrDone (clrDone),
    .clrWrEn (w_clr_we),
    .clrIdx  (w_clr_idx)
  );

  assign w_r1_ok  = (32'(read1RegSel) < NUM_REGS);
  assign w_r2_ok  = (32'(read2RegSel) < NUM_REGS);
  assign w_wr_rng = (32'(writeRegSel) < NUM_REGS);
  assign w_wr_ok  = writeEn && w_idle && w_wr_rng;

  // Bypass only when the write will actually land this edge.
  assign w_byp1 = BYPASS && w_wr_ok
                  && (writeRegSel == read1RegSel);
  assign w_byp2 = BYPASS && w_wr_ok
                  && (writeRegSel == read2RegSel);

  assign w_rd1 = w_r1_ok ? r_regs[read1RegSel] : '0;
  assign w_rd2 = w_r2_ok ? r_regs[read2RegSel] : '0;

  assign read1Data = w_byp1 ? writeData : w_rd1;
  assign read2Data = w_byp2 ? writeData : w_rd2;

  assign w_illegal = (writeEn && !w_idle)
                   || (writeEn && !w_wr_rng)
                   || !w_r1_ok
                   || !w_r2_ok;

  // Clear writes and user writes are exclusive by FSM state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        r_regs[i] <= '0;
    end else if (w_clr_we) begin
      r_regs[w_clr_idx] <= '0;
    end else if (w_wr_ok) begin
      r_regs[writeRegSel] <= writeData;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_err <= 1'b0;
    else
      r_err <= w_illegal;
  end

  assign err = r_err;

endmodule

// File: tb/tb_regfile_param_clr.sv
// Directed bench for regfile_param_clr: default, 6-entry and
// no-bypass instances checked against hand-computed values.
module tb_regfile_param_clr;

  logic        clk;
  logic        rst;
  logic [2:0]  r1, r2, ws;
  logic [15:0] wd;
  logic        we, cr;
  logic [15:0] a_rd1, a_rd2;
  logic        a_busy, a_done, a_err;
  logic [15:0] n_rd1, n_rd2;
  logic        n_busy, n_done, n_err;

  logic [2:0]  s_r1, s_r2, s_ws;
  logic [15:0] s_wd;
  logic        s_we, s_cr;
  logic [15:0] s_rd1, s_rd2;
  logic        s_busy, s_done, s_err;

  int errors;
  int checks;

  regfile_param_clr dut (
    .clk(clk), .rst(rst),
    .read1RegSel(r1), .read2RegSel(r2),
    .writeRegSel(ws), .writeData(wd),
    .writeEn(we), .clrReq(cr),
    .read1Data(a_rd1), .read2Data(a_rd2),
    .clrBusy(a_busy), .clrDone(a_done), .err(a_err)
  );

  regfile_param_clr #(.BYPASS(1'b0)) dutnb (
    .clk(clk), .rst(rst),
    .read1RegSel(r1), .read2RegSel(r2),
    .writeRegSel(ws), .writeData(wd),
    .writeEn(we), .clrReq(cr),
    .read1Data(n_rd1), .read2Data(n_rd2),
    .clrBusy(n_busy), .clrDone(n_done), .err(n_err)
  );

  regfile_param_clr #(.NUM_REGS(6)) dut6 (
    .clk(clk), .rst(rst),
    .read1RegSel(s_r1), .read2RegSel(s_r2),
    .writeRegSel(s_ws), .writeData(s_wd),
    .writeEn(s_we), .clrReq(s_cr),
    .read1Data(s_rd1), .read2Data(s_rd2),
    .clrBusy(s_busy), .clrDone(s_done), .err(s_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    step();
    step();
    for (int i = 0; i < 8; i++) begin
      r1 = 3'(i);
      r2 = 3'(7 - i);
      #1;
      checks++;
      if (a_rd1 !== 16'h0) begin
        errors++;
        $display("FAIL rst_rd1[%0d] got=%h exp=0000", i, a_rd1);
      end
      checks++;
      if (a_rd2 !== 16'h0) begin
        errors++;
        $display("FAIL rst_rd2[%0d] got=%h exp=0000", i, a_rd2);
      end
    end
    checks++;
    if ({a_busy, a_done, a_err} !== 3'b000) begin
      errors++;
      $display("FAIL rst_flags got=%b exp=000",
               {a_busy, a_done, a_err});
    end
    checks++;
    if ({s_busy, s_done, s_err} !== 3'b000) begin
      errors++;
      $display("FAIL rst_flags6 got=%b exp=000",
               {s_busy, s_done, s_err});
    end
    rst = 1'b1;
    r1 = 3'd0;
    r2 = 3'd0;
    step();
  endtask

  task automatic test_write_read;
    we = 1'b1;
    ws = 3'd3;
    wd = 16'hBEEF;
    step();
    we = 1'b0;
    r1 = 3'd3;
    #1;
    checks++;
    if (a_rd1 !== 16'hBEEF) begin
      errors++;
      $display("FAIL wr_rd got=%h exp=beef", a_rd1);
    end
    checks++;
    if (a_err !== 1'b0) begin
      errors++;
      $display("FAIL wr_err got=%b exp=0", a_err);
    end
  endtask

  task automatic test_bypass;
    we = 1'b1;
    ws = 3'd5;
    wd = 16'h1111;
    step();
    wd = 16'h1234;
    r1 = 3'd5;
    r2 = 3'd5;
    #1;
    checks++;
    if (a_rd2 !== 16'h1234) begin
      errors++;
      $display("FAIL byp_rd2 got=%h exp=1234", a_rd2);
    end
    checks++;
    if (a_rd1 !== 16'h1234) begin
      errors++;
      $display("FAIL byp_rd1 got=%h exp=1234", a_rd1);
    end
    checks++;
    if (n_rd2 !== 16'h1111) begin
      errors++;
      $display("FAIL nobyp_rd2 got=%h exp=1111", n_rd2);
    end
    step();
    we = 1'b0;
    #1;
    checks++;
    if (n_rd2 !== 16'h1234) begin
      errors++;
      $display("FAIL nobyp_stored got=%h exp=1234", n_rd2);
    end
  endtask

  task automatic test_clear;
    logic [15:0] e1, e2;
    for (int i = 0; i < 8; i++) begin
      we = 1'b1;
      ws = 3'(i);
      wd = 16'hFFFF;
      step();
    end
    we = 1'b0;
    cr = 1'b1;
    step();
    cr = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      r1 = 3'd0;
      r2 = 3'd7;
      #1;
      e1 = (c >= 2) ? 16'h0 : 16'hFFFF;
      e2 = (c <= 8) ? 16'hFFFF : 16'h0;
      checks++;
      if (a_busy !== (c <= 8)) begin
        errors++;
        $display("FAIL clr_busy c%0d got=%b", c, a_busy);
      end
      checks++;
      if (a_done !== (c == 9)) begin
        errors++;
        $display("FAIL clr_done c%0d got=%b", c, a_done);
      end
      checks++;
      if (a_rd1 !== e1) begin
        errors++;
        $display("FAIL clr_r0 c%0d got=%h exp=%h", c, a_rd1, e1);
      end
      checks++;
      if (a_rd2 !== e2) begin
        errors++;
        $display("FAIL clr_r7 c%0d got=%h exp=%h", c, a_rd2, e2);
      end
      step();
    end
    for (int i = 0; i < 8; i++) begin
      r1 = 3'(i);
      #1;
      checks++;
      if (a_rd1 !== 16'h0) begin
        errors++;
        $display("FAIL clr_all[%0d] got=%h exp=0000", i, a_rd1);
      end
    end
  endtask

  task automatic test_write_in_clear;
    int n;
    cr = 1'b1;
    step();
    cr = 1'b0;
    step();
    step();
    we = 1'b1;
    ws = 3'd0;
    wd = 16'hABCD;
    r1 = 3'd0;
    #1;
    checks++;
    if (a_err !== 1'b0) begin
      errors++;
      $display("FAIL wic_err0 got=%b exp=0", a_err);
    end
    checks++;
    if (a_rd1 !== 16'h0) begin
      errors++;
      $display("FAIL wic_nobyp got=%h exp=0000", a_rd1);
    end
    step();
    we = 1'b0;
    #1;
    checks++;
    if (a_err !== 1'b1) begin
      errors++;
      $display("FAIL wic_err1 got=%b exp=1", a_err);
    end
    checks++;
    if (a_rd1 !== 16'h0) begin
      errors++;
      $display("FAIL wic_r0 got=%h exp=0000", a_rd1);
    end
    step();
    checks++;
    if (a_err !== 1'b0) begin
      errors++;
      $display("FAIL wic_err2 got=%b exp=0", a_err);
    end
    n = 0;
    while (!a_done && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (a_done !== 1'b1) begin
      errors++;
      $display("FAIL wic_done_timeout got=%b exp=1", a_done);
    end
    step();
    #1;
    checks++;
    if (a_rd1 !== 16'h0) begin
      errors++;
      $display("FAIL wic_r0_end got=%h exp=0000", a_rd1);
    end
  endtask

  task automatic test_out_of_range;
    s_r1 = 3'd7;
    #1;
    checks++;
    if (s_rd1 !== 16'h0) begin
      errors++;
      $display("FAIL oob_rd got=%h exp=0000", s_rd1);
    end
    checks++;
    if (s_err !== 1'b0) begin
      errors++;
      $display("FAIL oob_err0 got=%b exp=0", s_err);
    end
    step();
    s_r1 = 3'd0;
    #1;
    checks++;
    if (s_err !== 1'b1) begin
      errors++;
      $display("FAIL oob_err1 got=%b exp=1", s_err);
    end
    s_we = 1'b1;
    s_ws = 3'd5;
    s_wd = 16'h6666;
    step();
    s_we = 1'b0;
    s_r2 = 3'd5;
    #1;
    checks++;
    if (s_rd2 !== 16'h6666) begin
      errors++;
      $display("FAIL six_r5 got=%h exp=6666", s_rd2);
    end
    checks++;
    if (s_err !== 1'b0) begin
      errors++;
      $display("FAIL six_err got=%b exp=0", s_err);
    end
    s_we = 1'b1;
    s_ws = 3'd6;
    s_wd = 16'h7777;
    step();
    s_we = 1'b0;
    #1;
    checks++;
    if (s_err !== 1'b1) begin
      errors++;
      $display("FAIL oob_wr_err got=%b exp=1", s_err);
    end
  endtask

  task automatic test_reset_mid_clear;
    int n;
    we = 1'b1;
    ws = 3'd6;
    wd = 16'h5555;
    step();
    ws = 3'd2;
    wd = 16'hAAAA;
    step();
    we = 1'b0;
    cr = 1'b1;
    step();
    cr = 1'b0;
    step();
    step();
    step();
    checks++;
    if (a_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy got=%b exp=1", a_busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (a_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_busy got=%b exp=0", a_busy);
    end
    r1 = 3'd6;
    r2 = 3'd2;
    #1;
    checks++;
    if (a_rd1 !== 16'h0) begin
      errors++;
      $display("FAIL mid_rst_r6 got=%h exp=0000", a_rd1);
    end
    checks++;
    if (a_rd2 !== 16'h0) begin
      errors++;
      $display("FAIL mid_rst_r2 got=%h exp=0000", a_rd2);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({a_busy, a_done} !== 2'b00) begin
      errors++;
      $display("FAIL mid_idle got=%b exp=00", {a_busy, a_done});
    end
    cr = 1'b1;
    step();
    cr = 1'b0;
    n = 0;
    while (a_busy && n < 20) begin
      n++;
      step();
    end
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL reclr_len got=%0d exp=8", n);
    end
    checks++;
    if (a_done !== 1'b1) begin
      errors++;
      $display("FAIL reclr_done got=%b exp=1", a_done);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    errors = 0;
    checks = 0;
    rst  = 1'b0;
    r1   = '0; r2 = '0; ws = '0; wd = '0;
    we   = 1'b0; cr = 1'b0;
    s_r1 = '0; s_r2 = '0; s_ws = '0; s_wd = '0;
    s_we = 1'b0; s_cr = 1'b0;
    test_reset();
    test_write_read();
    test_bypass();
    test_clear();
    test_write_in_clear();
    test_out_of_range();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_param_clr.md
Name: regfile_param_clr

Overview:
- Parametrised multi-register file: generalised width and depth, two combinational read ports and one write port.
- Adds optional write-to-read bypass, a sequenced bulk-clear engine with busy/done handshake, and a registered error pulse for illegal accesses.
- Sits in the decode stage of the pipelined CPU as the successor to the fixed 8x16 register file.
- Shared by the RF and by multi-bank configurations through WIDTH and NUM_REGS.

Parameters:
- WIDTH, 16, data width of each register in bits.
- NUM_REGS, 8, number of registers; any value from 2 to 64, power of two not required.
- SEL_W, $clog2(NUM_REGS), width of the register select fields.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = reads return the stored value only.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- read1RegSel  input  SEL_W  read port 1 register select.
- read2RegSel  input  SEL_W  read port 2 register select.
- writeRegSel  input  SEL_W  write register select.
- writeData  input  WIDTH  write data.
- writeEn  input  1  write enable.
- clrReq  input  1  bulk-clear request, sampled at the rising edge.
- read1Data  output  WIDTH  read port 1 data, combinational.
- read2Data  output  WIDTH  read port 2 data, combinational.
- clrBusy  output  1  high while the clear sequence runs.
- clrDone  output  1  one-cycle pulse when the clear completes.
- err  output  1  registered one-cycle pulse flagging an illegal access.

Behaviour:
- Reset (rst low, asynchronous):
  - all registers 0; FSM in IDLE; clear index 0.
  - clrBusy=0, clrDone=0, err=0.
  - Reset takes effect immediately, including mid-clear; no residual state survives.
- Reads (combinational):
  - readNData = reg[readNRegSel].
  - A select >= NUM_REGS returns 0 and flags err.
- Bypass: active when BYPASS=1, FSM in IDLE, writeEn=1, writeRegSel valid and writeRegSel==readNRegSel.
  - readNData = writeData in the same cycle.
  - Both read ports may bypass simultaneously.
- Writes: reg[writeRegSel] <= writeData at the rising edge when all of the following hold:
  - writeEn=1;
  - FSM in IDLE;
  - writeRegSel < NUM_REGS.
- FSM states: IDLE, CLEAR, DONE.
  - IDLE: clrReq=1 at the edge -> CLEAR, index <= 0. A write in that same edge is still performed, then overwritten by the clear.
  - CLEAR: each edge writes reg[index] <= 0 and index <= index+1. When index==NUM_REGS-1 -> DONE.
  - CLEAR duration: exactly NUM_REGS cycles.
  - DONE: lasts one cycle, then -> IDLE.
- Outputs per state:
  - clrBusy=1 in CLEAR only.
  - clrDone=1 in DONE only.
- Reads during CLEAR return current contents: already-cleared entries read 0. Bypass is disabled during CLEAR and DONE.
- clrReq in CLEAR or DONE is ignored; it is not queued.
- writeEn in CLEAR or DONE is dropped with no state change and flags err.
- err is registered: high in the cycle after any illegal event in the previous cycle. Illegal events:
  - write while not IDLE;
  - writeRegSel out of range with writeEn=1;
  - any read select out of range.
- Index counter width is SEL_W; it never wraps because the FSM exits at NUM_REGS-1.

Decomposition:
- Shared package (regfile_pkg): FSM state encoding constants (IDLE=2'd0, CLEAR=2'd1, DONE=2'd2) and the clog2 helper function.
- One natural sub-module: regfile_clr_fsm.
  - Owns the state register, index counter, clrBusy and clrDone.
  - Outputs clrWrEn and clrIdx to the storage array.
- Storage array, bypass muxes and err logic stay in the top level.

Test Plan:
- Reset then read all registers: every readNData = 0; clrBusy=0, clrDone=0, err=0.
- Write 16'hBEEF to r3, next cycle read1RegSel=3 -> 16'hBEEF.
- Bypass, BYPASS=1: writeEn=1, writeRegSel=5, writeData=16'h1234, read2RegSel=5 in the same cycle -> read2Data=16'h1234 before the edge. With BYPASS=0 -> old value.
- Fill r0..r7 with 16'hFFFF, pulse clrReq for one cycle:
  - clrBusy high for exactly 8 cycles;
  - clrDone pulses once in cycle 9;
  - all reads return 0 afterward.
- writeEn=1 during CLEAR: target keeps its cleared value (0); err=1 exactly one cycle later.
- NUM_REGS=6 with read1RegSel=7 -> read1Data=0 and err pulse next cycle.
- Assert rst low mid-clear at index 3: clrBusy drops immediately; all registers 0; the FSM accepts a new clrReq after rst returns high.
